// File: rtl/thread_issue_sched_pkg.sv
// ============================================================================
// Module : common (package)
// Brief  : Shared thread-count, id/pointer types, boot PC and scheduler state.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package common;
    localparam int n_threads = 4;

    typedef logic [$clog2(n_threads)-1:0] threadid_t;
    typedef logic [31:0]                  vptr_t;

    localparam vptr_t boot_pc = 32'h0000_1000;

    typedef enum logic {SCHED_RUN, SCHED_EXC} sched_state_t;
endpackage

`default_nettype wire

// File: rtl/thread_issue_sched_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick of the first request after i_last.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_last,
    output logic [$clog2(N)-1:0] o_grant,
    output logic                 o_any
);
    localparam int W = $clog2(N);

    int w_idx;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(i_last) + k) % N;
            if (i_req[w_idx]) begin
                o_grant = W'(w_idx);
                o_any   = 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/thread_issue_sched.sv
// ============================================================================
// Module : thread_issue_sched
// Brief  : Per-thread fetch PCs, round-robin issue to fetch, exception-master
//          restriction. Optional THREAD_ISSUE_SCHED_REDIRECT_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module thread_issue_sched
    import common::*;
#(
    parameter int          N_THREADS = n_threads,
    parameter logic [31:0] BOOT_PC   = boot_pc
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_THREADS-1:0]         thread_en,
    input  logic [N_THREADS-1:0]         wb_pc_en,
    input  logic [31:0]                  wb_pc_data,
    input  logic                         wb_exc_en,
    input  logic [$clog2(N_THREADS)-1:0] wb_exc_thread,
    output logic                         if_valid,
    input  logic                         if_ready,
    output logic [$clog2(N_THREADS)-1:0] if_thread,
    output logic [31:0]                  if_pc,
    output logic                         exc_mode
);
    localparam int TW = $clog2(N_THREADS);

    logic [31:0]          r_pc [N_THREADS];
    logic [TW-1:0]        r_rr_last;
    logic                 r_valid;
    logic [TW-1:0]        r_thread;
    logic [31:0]          r_pc_out;
    logic                 r_exc_mode;
    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic                 w_exc_next;

    logic [N_THREADS-1:0] w_eligible;
    logic [N_THREADS-1:0] w_issue;
    logic [TW-1:0]        w_grant;
    logic                 w_any;
    logic                 w_load;
    logic [31:0]          w_sel_pc;

    assign w_load = !r_valid || if_ready;

    generate
        for (genvar i = 0; i < N_THREADS; i++) begin : g_elig
            assign w_eligible[i] = thread_en[i] &&
                                   ((r_state == SCHED_RUN) || (wb_exc_thread == TW'(i)));
            assign w_issue[i]    = w_load && w_any && (w_grant == TW'(i));
        end
    endgenerate

    rr_arbiter #(
        .N (N_THREADS)
    ) u_arb (
        .i_req   (w_eligible),
        .i_last  (r_rr_last),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

`ifdef THREAD_ISSUE_SCHED_REDIRECT_BYPASS_EN
    assign w_sel_pc = wb_pc_en[w_grant] ? wb_pc_data : r_pc[w_grant];
`else
    assign w_sel_pc = r_pc[w_grant];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                r_pc[i] <= BOOT_PC;
            end
        end else begin
            for (int i = 0; i < N_THREADS; i++) begin
`ifdef THREAD_ISSUE_SCHED_REDIRECT_BYPASS_EN
                if (w_issue[i]) begin
                    r_pc[i] <= w_sel_pc + 32'd4;
                end else if (wb_pc_en[i]) begin
                    r_pc[i] <= wb_pc_data;
                end
`else
                // A redirect wins over the increment; the stale slot is dropped downstream.
                if (wb_pc_en[i]) begin
                    r_pc[i] <= wb_pc_data;
                end else if (w_issue[i]) begin
                    r_pc[i] <= r_pc[i] + 32'd4;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_thread  <= '0;
            r_pc_out  <= BOOT_PC;
            r_rr_last <= TW'(N_THREADS - 1);
        end else if (w_load) begin
            if (w_any) begin
                r_valid   <= 1'b1;
                r_thread  <= w_grant;
                r_pc_out  <= w_sel_pc;
                r_rr_last <= w_grant;
            end else begin
                r_valid   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SCHED_RUN;
            r_exc_mode <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_exc_mode <= w_exc_next;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SCHED_RUN: if (wb_exc_en)  w_state_nxt = SCHED_EXC;
            SCHED_EXC: if (!wb_exc_en) w_state_nxt = SCHED_RUN;
            default:                   w_state_nxt = SCHED_RUN;
        endcase
    end

    always_comb begin
        w_exc_next = (w_state_nxt == SCHED_EXC);
    end

    assign if_valid  = r_valid;
    assign if_thread = r_thread;
    assign if_pc     = r_pc_out;
    assign exc_mode  = r_exc_mode;
endmodule

`default_nettype wire

// File: tb/tb_thread_issue_sched.sv
// ============================================================================
// Module : tb_thread_issue_sched
// Brief  : Scoreboard bench for thread_issue_sched issue order, stalls,
//          redirects, exception restriction and asynchronous reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_thread_issue_sched;
    logic        clk;
    logic        rst;
    logic [3:0]  thread_en;
    logic [3:0]  wb_pc_en;
    logic [31:0] wb_pc_data;
    logic        wb_exc_en;
    logic [1:0]  wb_exc_thread;
    logic        if_valid;
    logic        if_ready;
    logic [1:0]  if_thread;
    logic [31:0] if_pc;
    logic        exc_mode;

    int n_cmp;
    int n_err;
    logic [63:0] q_exp [$];

    thread_issue_sched u_dut (
        .clk           (clk),
        .rst           (rst),
        .thread_en     (thread_en),
        .wb_pc_en      (wb_pc_en),
        .wb_pc_data    (wb_pc_data),
        .wb_exc_en     (wb_exc_en),
        .wb_exc_thread (wb_exc_thread),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_thread     (if_thread),
        .if_pc         (if_pc),
        .exc_mode      (exc_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic exp_issue(input int t, input logic [31:0] pc);
        q_exp.push_back({32'(t), pc});
    endtask

    // Called at a negedge with inputs already set for the coming posedge.
    task automatic cycle();
        logic [63:0] e;
        if (if_valid && if_ready) begin
            if (q_exp.size() == 0) begin
                check("spurious_issue", 32'(q_exp.size()), 32'd1);
            end else begin
                e = q_exp.pop_front();
                check("if_thread", 32'(if_thread), e[63:32]);
                check("if_pc", if_pc, e[31:0]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int budget = 40;
        while (q_exp.size() != 0 && budget > 0) begin
            cycle();
            budget--;
        end
        check("drain_remaining", 32'(q_exp.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        thread_en = 4'b0000;
        wb_pc_en  = 4'b0000;
        wb_exc_en = 1'b0;
        if_ready  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        thread_en     = 4'b0000;
        wb_pc_en      = 4'b0000;
        wb_pc_data    = 32'h0;
        wb_exc_en     = 1'b0;
        wb_exc_thread = 2'd0;
        if_ready      = 1'b1;
        #2;
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_thread", 32'(if_thread), 32'd0);
        check("rst_pc", if_pc, 32'h1000);
        check("rst_exc_mode", 32'(exc_mode), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full round robin from reset
        thread_en = 4'b1111;
        exp_issue(0, 32'h1000); exp_issue(1, 32'h1000); exp_issue(2, 32'h1000);
        exp_issue(3, 32'h1000); exp_issue(0, 32'h1004);
        drain();

        // Stall on (1,0x1004) with a redirect to thread 1 during the stall
        if_ready   = 1'b0;
        wb_pc_en   = 4'b0010;
        wb_pc_data = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            wb_pc_en = 4'b0000;
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_thread", 32'(if_thread), 32'd1);
            check("stall_pc", if_pc, 32'h1004);
        end
        if_ready = 1'b1;
        exp_issue(1, 32'h1004); exp_issue(2, 32'h1004); exp_issue(3, 32'h1004);
        exp_issue(0, 32'h1008); exp_issue(1, 32'h2000); exp_issue(2, 32'h1008);
        exp_issue(3, 32'h1008); exp_issue(0, 32'h100C); exp_issue(1, 32'h2004);
        drain();

        // Sparse enable, then no enable
        do_reset();
        thread_en = 4'b0101;
        exp_issue(0, 32'h1000); exp_issue(2, 32'h1000);
        exp_issue(0, 32'h1004); exp_issue(2, 32'h1004);
        drain();
        thread_en = 4'b0000;
        exp_issue(0, 32'h1008);
        cycle();
        check("idle_valid", 32'(if_valid), 32'd0);
        check("idle_queue", 32'(q_exp.size()), 32'd0);

        // Exception restriction to master thread 2
        do_reset();
        thread_en     = 4'b1111;
        wb_exc_en     = 1'b1;
        wb_exc_thread = 2'd2;
        cycle();
        check("exc_mode_on", 32'(exc_mode), 32'd1);
        exp_issue(0, 32'h1000); exp_issue(2, 32'h1000);
        exp_issue(2, 32'h1004); exp_issue(2, 32'h1008);
        drain();
        wb_exc_en = 1'b0;
        exp_issue(2, 32'h100C); exp_issue(2, 32'h1010); exp_issue(3, 32'h1000);
        exp_issue(0, 32'h1004); exp_issue(1, 32'h1000);
        cycle();
        check("exc_mode_off", 32'(exc_mode), 32'd0);
        drain();

        // Redirect in the same cycle the thread is selected
        do_reset();
        thread_en  = 4'b1111;
        wb_pc_en   = 4'b0001;
        wb_pc_data = 32'h3000;
        cycle();
        wb_pc_en = 4'b0000;
`ifdef THREAD_ISSUE_SCHED_REDIRECT_BYPASS_EN
        exp_issue(0, 32'h3000);
`else
        exp_issue(0, 32'h1000);
`endif
        exp_issue(1, 32'h1000); exp_issue(2, 32'h1000); exp_issue(3, 32'h1000);
`ifdef THREAD_ISSUE_SCHED_REDIRECT_BYPASS_EN
        exp_issue(0, 32'h3004);
`else
        exp_issue(0, 32'h3000);
`endif
        drain();

        // Asynchronous reset mid-stall
        if_ready = 1'b0;
        cycle();
        check("pre_arst_valid", 32'(if_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", 32'(if_valid), 32'd0);
        check("arst_thread", 32'(if_thread), 32'd0);
        check("arst_pc", if_pc, 32'h1000);
        check("arst_exc_mode", 32'(exc_mode), 32'd0);
        #3 rst = 1'b0;
        @(negedge clk);
        if_ready = 1'b1;
        exp_issue(0, 32'h1000); exp_issue(1, 32'h1000); exp_issue(2, 32'h1000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/thread_issue_sched.md
Name: thread_issue_sched

Overview:
- Front-end thread scheduler. Consumes the writeback stage's PC-redirect and exception-force outputs (pc_en/pc_data, exc_en/exc_thread).
- Holds one architectural fetch PC per hardware thread and issues one (thread, PC) pair per cycle to fetch over a valid/ready handshake.
- Threads are picked round-robin. While writeback signals exception state, issue is restricted to the exception master thread.

Parameters:
- N_THREADS, 4, number of hardware threads; must equal common::n_threads.
- BOOT_PC, 32'h1000, reset PC of every thread; must match writeback's reset waiting PC.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- thread_en  in  N_THREADS  per-thread issue enable mask
- wb_pc_en  in  N_THREADS  redirect strobe per thread (writeback pc_en)
- wb_pc_data  in  32  redirect target (vptr_t), shared by all strobes
- wb_exc_en  in  1  writeback exception state active
- wb_exc_thread  in  $clog2(N_THREADS)  exception master thread (threadid_t)
- if_valid  out  1  issue slot valid
- if_ready  in  1  fetch accepts slot
- if_thread  out  $clog2(N_THREADS)  issued thread id
- if_pc  out  32  issued PC
- exc_mode  out  1  scheduler is in EXC state

Behaviour:
- Reset (async, rst=1):
  - pc_reg[i]=BOOT_PC for all i; rr_last=N_THREADS-1; state=RUN.
  - Outputs: if_valid=0, if_thread=0, if_pc=BOOT_PC, exc_mode=0.
  - Reset asserted mid-operation discards the in-flight slot and all redirects immediately.
- All outputs are registered.
- Load condition: load = !if_valid || if_ready. While if_valid && !if_ready, if_thread and if_pc hold stable.
- Eligibility:
  - RUN: eligible[i] = thread_en[i].
  - EXC: eligible[i] = (i == wb_exc_thread) && thread_en[i].
- Selection: first eligible thread strictly after rr_last, modulo N_THREADS with wrap to 0. If none is eligible, a load cycle drives if_valid<=0.
- On load with selected thread t:
  - if_valid<=1, if_thread<=t, if_pc<=pc_reg[t], rr_last<=t.
  - pc_reg[t]<=pc_reg[t]+4 (32-bit, wraps modulo 2^32).
- Redirect:
  - Every i with wb_pc_en[i]=1 takes pc_reg[i]<=wb_pc_data.
  - Redirect beats increment for the same thread in the same cycle. The slot issued that cycle carries the old PC, and writeback drops it as a PC mismatch.
  - Multiple set bits all load the same data.
  - A redirect to the thread held in a stalled slot does not alter the held slot.
- State machine, evaluated every cycle:
  - RUN -> EXC when wb_exc_en=1.
  - EXC -> RUN when wb_exc_en=0.
  - exc_mode<=(next state==EXC).
  - wb_exc_thread is sampled every cycle while in EXC.
  - Eligibility uses the current (registered) state, so issue restriction starts one cycle after wb_exc_en rises.
- Stall with state change: an already-valid slot of a non-master thread is not revoked; it completes the handshake.
- Latency: redirect to first issue of the new PC is 1 cycle minimum, since pc_reg updates at the clock edge.

Optional Feature:
- Macro: THREAD_ISSUE_SCHED_REDIRECT_BYPASS_EN.
- Defined: on a load cycle where the selected t has wb_pc_en[t]=1, if_pc<=wb_pc_data and pc_reg[t]<=wb_pc_data+4. This removes the wasted stale slot.
- Undefined: behaviour as in Behaviour (stale PC issued, redirect lands in pc_reg).

Decomposition:
- Package common holds n_threads, threadid_t, vptr_t, and a boot_pc constant; the BOOT_PC default references it.
- Add typedef enum logic {SCHED_RUN, SCHED_EXC} sched_state_t to common.
- One sub-module: rr_arbiter (N_THREADS request vector + last-grant pointer -> grant index + any_grant, combinational).
- PC registers, state machine and output register stay in thread_issue_sched.

Test Plan:
- Reset, thread_en=4'b1111, if_ready=1 -> issues (0,0x1000), (1,0x1000), (2,0x1000), (3,0x1000), (0,0x1004).
- thread_en=4'b0101, if_ready=1 -> threads alternate 0,2,0,2 with PCs 0x1000, 0x1000, 0x1004, 0x1004; no issue of 1 or 3. thread_en=0 -> if_valid=0 next cycle.
- Slot (1,0x1004) valid, if_ready=0 for 3 cycles, wb_pc_en=4'b0010 with wb_pc_data=0x2000 during the stall -> slot holds (1,0x1004); the next issue of thread 1 is 0x2000, then 0x2004.
- wb_exc_en=1, wb_exc_thread=2 -> exc_mode=1 next cycle; only thread 2 issued, PC incrementing by 4. wb_exc_en=0 -> round-robin resumes from thread 3.
- Redirect wb_pc_en[t]=1 to 0x3000 in the same cycle t is selected:
  - Without the macro: issued pc_reg[t] (old), next issue of t is 0x3000.
  - With the macro: issued 0x3000, next issue of t is 0x3004.
- rst pulsed asynchronously mid-stall, not clock-aligned -> if_valid=0 immediately, all PCs back to 0x1000, first post-reset issue is thread 0.
